fsm_traffic_timed: RTL and testbench

Parametrised successor to the two-street traffic-light controller with parade mode. It adds per-phase cycle timers: a minimum green time, a fixed yellow duration and an all-red clearance interval. It also exposes the current phase for debug and monitoring. It sits at intersection-control level, driven by street sensors and parade request/release pulses.

---
 rtl/fsm_traffic_pkg.sv | 35 +++
 rtl/fsm_traffic_timed_phase_timer.sv | 31 +++
 rtl/fsm_traffic_timed.sv | 89 ++++++++
 tb/tb_fsm_traffic_timed.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module : fsm_traffic_pkg
// Brief  : Light/state encodings and the state-to-lights decode shared by the
//          timed two-street traffic controller.
// Rev    : 1.0 - initial release
// ============================================================================
package fsm_traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [2:0] {
    S_AG = 3'd0,  // A green,  B red
    S_AY = 3'd1,  // A yellow, B red
    S_AR = 3'd2,  // all red, handing over to B
    S_BG = 3'd3,  // B green,  A red
    S_BY = 3'd4,  // B yellow, A red
    S_BR = 3'd5   // all red, handing over to A
  } state_t;

  // Returns {La, Lb}; unused codes decode to all-red so the lights stay safe
  function automatic logic [3:0] lights_of(input state_t s);
    case (s)
      S_AG:    lights_of = {GREEN,  RED};
      S_AY:    lights_of = {YELLOW, RED};
      S_BG:    lights_of = {RED,    GREEN};
      S_BY:    lights_of = {RED,    YELLOW};
      default: lights_of = {RED,    RED};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_traffic_timed_phase_timer.sv
`default_nettype none
// ============================================================================
// Module : phase_timer
// Brief  : Saturating count of cycles spent in the current phase; cleared on
//          the edge the FSM changes state.
// Rev    : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up each cycle, restart on phase change, hold at full scale
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsm_traffic_timed.sv
`default_nettype none
// ============================================================================
// Module : fsm_traffic_timed
// Brief  : Two-street traffic controller with parade mode, minimum green,
//          fixed yellow and all-red clearance timing. Moore outputs.
// Rev    : 1.0 - initial release
// ============================================================================
module fsm_traffic_timed
  import fsm_traffic_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int MIN_GRN_CYC = 4,
  parameter int YEL_CYC     = 2,
  parameter int ALLRED_CYC  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             Ta,
  input  logic             Tb,
  input  logic             P,
  input  logic             R,
  output logic [1:0]       La,
  output logic [1:0]       Lb,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cnt
);

  // Last count value of each phase (green uses it as a minimum)
  localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(MIN_GRN_CYC - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);

  state_t state;
  state_t state_nxt;
  logic   mode;
  logic   state_chg;

  // Transition rules; parade mode pushes A out of green and pins B green
  always_comb begin
    state_nxt = state;
    case (state)
      S_AG: if (cnt >= GRN_LAST && (!Ta || mode))  state_nxt = S_AY;
      S_AY: if (cnt == YEL_LAST)                   state_nxt = S_AR;
      S_AR: if (cnt == AR_LAST)                    state_nxt = S_BG;
      S_BG: if (cnt >= GRN_LAST && !Tb && !mode)   state_nxt = S_BY;
      S_BY: if (cnt == YEL_LAST)                   state_nxt = S_BR;
      S_BR: if (cnt == AR_LAST)                    state_nxt = S_AG;
      default:                                     state_nxt = S_AG;
    endcase
  end

  assign state_chg = (state_nxt != state);

  // State register with lights and phase registered alongside it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_AG;
      La    <= GREEN;
      Lb    <= RED;
      phase <= 3'd0;
    end else begin
      state    <= state_nxt;
      {La, Lb} <= lights_of(state_nxt);
      phase    <= state_nxt;
    end
  end

  // Parade mode register: release has priority over request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode <= 1'b0;
    end else if (R) begin
      mode <= 1'b0;
    end else if (P) begin
      mode <= 1'b1;
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_chg),
    .cnt  (cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_fsm_traffic_timed.sv
`default_nettype none
// ============================================================================
// Module : tb_fsm_traffic_timed
// Brief  : Self-checking bench for fsm_traffic_timed: directed scenarios plus
//          randomized traffic against a phase/dwell-time reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fsm_traffic_timed;

  localparam int CNT_W   = 4;
  localparam int MIN_GRN = 4;
  localparam int YEL     = 2;
  localparam int ALLRED  = 1;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn, ta, tb, p, r;
  logic [1:0]       la, lb;
  logic [2:0]       phase;
  logic [CNT_W-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase index 0..5, unbounded time in phase, parade flag
  int m_ph = 0;
  int m_t  = 0;
  bit m_m  = 1'b0;
  int la_tab[6]     = '{0, 1, 2, 2, 2, 2};
  int lb_tab[6]     = '{2, 2, 2, 0, 1, 2};
  int dwell_last[6] = '{MIN_GRN-1, YEL-1, ALLRED-1, MIN_GRN-1, YEL-1, ALLRED-1};

  always #5 clk = ~clk;

  fsm_traffic_timed #(
    .CNT_W       (CNT_W),
    .MIN_GRN_CYC (MIN_GRN),
    .YEL_CYC     (YEL),
    .ALLRED_CYC  (ALLRED)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .Ta    (ta),
    .Tb    (tb),
    .P     (p),
    .R     (r),
    .La    (la),
    .Lb    (lb),
    .phase (phase),
    .cnt   (cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs that were present at it
  task automatic model_step();
    bit go;
    if (!rstn) begin
      m_ph = 0;
      m_t  = 0;
      m_m  = 1'b0;
      return;
    end
    case (m_ph)
      0:       go = (m_t >= MIN_GRN-1) && (!ta || m_m);
      3:       go = (m_t >= MIN_GRN-1) && !tb && !m_m;
      default: go = (m_t == dwell_last[m_ph]);
    endcase
    if (go) begin
      m_ph = (m_ph + 1) % 6;
      m_t  = 0;
    end else begin
      m_t = m_t + 1;
    end
    if (r)      m_m = 1'b0;
    else if (p) m_m = 1'b1;
  endtask

  task automatic step(input bit rn, input bit a, input bit b, input bit pp, input bit rr);
    rstn = rn; ta = a; tb = b; p = pp; r = rr;
    @(posedge clk);
    model_step();
    #1;
    check_eq("La",    la,    la_tab[m_ph]);
    check_eq("Lb",    lb,    lb_tab[m_ph]);
    check_eq("phase", phase, m_ph);
    check_eq("cnt",   cnt,   (m_t > CNT_SAT) ? CNT_SAT : m_t);
    check_eq("safety", (la != 2'b10) && (lb != 2'b10), 0);
  endtask

  // Step with fixed sensors until the model reaches a phase, bounded
  task automatic run_to(input int target, input bit a, input bit b, input int budget, input string tag);
    int k = 0;
    while (m_ph != target && k < budget) begin
      step(1'b1, a, b, 1'b0, 1'b0);
      k++;
    end
    check_eq(tag, phase, target);
  endtask

  initial begin
    rstn = 1'b0; ta = 1'b0; tb = 1'b0; p = 1'b0; r = 1'b0;

    // Reset with random sensor/parade inputs
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_eq("rst_La",    la,    0);
      check_eq("rst_Lb",    lb,    2);
      check_eq("rst_phase", phase, 0);
      check_eq("rst_cnt",   cnt,   0);
    end

    // Default cycle with no traffic
    for (int e = 1; e <= 14; e++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 4)  check_eq("dflt_ay_e4",  phase, 1);
      if (e == 6)  check_eq("dflt_ar_e6",  phase, 2);
      if (e == 7)  check_eq("dflt_bg_e7",  phase, 3);
      if (e == 13) check_eq("dflt_br_e13", phase, 5);
      if (e == 14) check_eq("dflt_ag_e14", phase, 0);
    end

    // B sensor holds green; counter saturates
    run_to(3, 1'b0, 1'b1, 10, "sat_reach_bg");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("sat_phase", phase, 3);
    check_eq("sat_cnt",   cnt,   15);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_exit_phase", phase, 4);
    check_eq("sat_exit_cnt",   cnt,   0);
    run_to(0, 1'b0, 1'b0, 10, "sat_back_ag");

    // Parade: P pulse forces A out despite traffic, B held green
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 4) check_eq("par_ag_hold", phase, 0);
    end
    check_eq("par_ay_e4", phase, 1);
    run_to(3, 1'b1, 1'b0, 10, "par_reach_bg");
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("par_bg_held", phase, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("par_rel_edge", phase, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("par_rel_by", phase, 4);

    // P and R together: release wins, A keeps green with traffic
    run_to(0, 1'b1, 1'b0, 10, "pr_back_ag");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pr_ag_phase", phase, 0);
    check_eq("pr_ag_cnt",   cnt,   11);

    // Reset while in BY with parade set
    run_to(4, 1'b0, 1'b0, 20, "mid_reach_by");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("mid_by_hold", phase, 4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mid_rst_phase", phase, 0);
    check_eq("mid_rst_cnt",   cnt,   0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("mid_mode_clr", phase, 0);

    // Randomized traffic, parade pulses and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
